// File: rtl/reaction_time_display.sv
// Freezes the elapsed-ms count, converts it to 4-digit BCD with a sequential
// double-dabble FSM and scans it onto a multiplexed active-low 7-segment display.
module reaction_time_display #(
  parameter int unsigned REFRESH_DIV = 25000,
  parameter int unsigned SAT_VALUE   = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic        stopsignal,
  input  logic [15:0] cur_sec,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [15:0]   SAT          = 16'(SAT_VALUE);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   bin_sr_q, bin_sr_d;
  logic [15:0]   bcd_sr_q, bcd_sr_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [15:0]   bcd_adj;
  logic [4:0]    iter_q, iter_d;
  logic          ovf_q, ovf_d;
  logic          bcd_valid_q, bcd_valid_d;
  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    digit;
  logic          blank;

  function automatic logic [6:0] seg_pattern(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    hold_d = hold_q;
    if (set)              hold_d = '0;
    else if (!stopsignal) hold_d = cur_sec;
  end

  always_comb begin
    bcd_adj = bcd_sr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_sr_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_sr_d    = bin_sr_q;
    bcd_sr_d    = bcd_sr_q;
    iter_d      = iter_q;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        ovf_d    = (hold_q > SAT);
        bin_sr_d = (hold_q > SAT) ? SAT : hold_q;
        bcd_sr_d = '0;
        iter_d   = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        {bcd_sr_d, bin_sr_d} = {bcd_adj[14:0], bin_sr_q, 1'b0};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd15) state_d = DONE;
      end
      DONE: begin
        // bcd and its valid strobe are registered together so they line up
        bcd_d       = bcd_sr_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refresh_d = (refresh_q == REFRESH_LAST) ? '0 : refresh_q + 1'b1;
    idx_d     = (refresh_q == REFRESH_LAST) ? idx_q + 2'd1 : idx_q;
    digit     = bcd_q[4*idx_q +: 4];
    case (idx_q)
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      2'd2:    blank = (bcd_q[15:8] == 8'd0);
      2'd1:    blank = (bcd_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
    seg_d = blank ? 7'h7F : seg_pattern(digit);
    an_d  = ~(4'b0001 << idx_q);
    dp_d  = ~((idx_q == 2'd3) & ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      bin_sr_q    <= '0;
      bcd_sr_q    <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      ovf_q       <= 1'b0;
      bcd_valid_q <= 1'b0;
      refresh_q   <= '0;
      idx_q       <= '0;
      an_q        <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      bin_sr_q    <= bin_sr_d;
      bcd_sr_q    <= bcd_sr_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      ovf_q       <= ovf_d;
      bcd_valid_q <= bcd_valid_d;
      refresh_q   <= refresh_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_reaction_time_display.sv
// Scoreboarded random test of reaction_time_display: expected BCD values are
// queued by the stimulus thread and popped by a monitor on every bcd_valid.
module tb_reaction_time_display;

  localparam int RD = 4;
  localparam logic [6:0] SEGTAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};
  localparam int unsigned P10 [4] = '{1, 10, 100, 1000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set = 1'b0;
  logic        stopsignal = 1'b0;
  logic [15:0] cur_sec = '0;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #20 clk = ~clk;

  reaction_time_display #(.REFRESH_DIV(RD), .SAT_VALUE(9999)) dut (
    .clk(clk), .rst_n(rst_n), .set(set), .stopsignal(stopsignal), .cur_sec(cur_sec),
    .bcd(bcd), .bcd_valid(bcd_valid), .an(an), .seg(seg), .dp(dp)
  );

  function automatic int unsigned sat(input int unsigned v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned v);
    int unsigned s = sat(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] seg_exp(input int unsigned v, input int k);
    int unsigned s = sat(v);
    if (k != 0 && s < P10[k]) return 7'h7F;
    return SEGTAB[(s / P10[k]) % 10];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic monitor();
    int n = 0;
    int last = -1;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      n++;
      if (!rst_n) last = -1;
      else if (bcd_valid) begin
        if (last >= 0) chk("valid_period", n - last, 19);
        last = n;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bcd", bcd, e);
        end
      end
    end
  endtask

  task automatic apply(input int unsigned v, input logic st, input logic sp);
    @(negedge clk);
    cur_sec = 16'(v); set = st; stopsignal = sp;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    chk("bcd_valid_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic sb_expect(input int unsigned held);
    tick(40);
    exp_q.push_back(to_bcd(held));
    drain();
  endtask

  task automatic check_display(input int unsigned v);
    logic [3:0] seen = '0;
    int k;
    for (int c = 0; c < 4 * RD + 2; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      chk("an_onehot", (k >= 0), 1);
      if (k >= 0) begin
        seen[k] = 1'b1;
        chk($sformatf("seg_digit%0d", k), seg, seg_exp(v, k));
        chk($sformatf("dp_digit%0d", k), dp, (k == 3 && v > 9999) ? 1'b0 : 1'b1);
      end
    end
    chk("scan_all_digits", seen, 4'hF);
  endtask

  task automatic check_reset_outputs();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_valid", bcd_valid, 1'b0);
  endtask

  task automatic release_and_expect(input int unsigned v);
    int lat = 0;
    logic early_bad = 1'b0;
    @(negedge clk);
    exp_q.push_back(to_bcd(v));
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (bcd_valid) begin lat = k; break; end
      if (bcd !== 16'h0000) early_bad = 1'b1;
    end
    chk("post_reset_latency_ok", (lat > 0 && lat <= 19), 1);
    chk("bcd_zero_before_first_valid", early_bad, 1'b0);
    drain();
  endtask

  initial begin
    int unsigned v;
    logic st;
    fork monitor(); join_none

    // 1: reset mid-run, then conversion of 0
    tick(2);
    apply(0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(27);
    #5 rst_n = 1'b0;
    #1 check_reset_outputs();
    tick(2);
    release_and_expect(0);
    check_display(0);

    // 2..4: directed values and saturation boundaries
    foreach (P10[i]) begin end
    begin
      int unsigned dir [10] = '{1234, 7, 12000, 50, 9999, 10000, 65535, 1000, 100, 10};
      foreach (dir[i]) begin
        apply(dir[i], 1'b0, 1'b0);
        sb_expect(dir[i]);
        check_display(dir[i]);
      end
    end

    // randomized values, occasionally in setup mode
    for (int i = 0; i < 12; i++) begin
      v  = $urandom_range(0, 20000);
      st = ($urandom_range(0, 5) == 0);
      apply(v, st, 1'b0);
      sb_expect(st ? 0 : v);
      if (i % 3 == 0) check_display(st ? 0 : v);
    end

    // 5: freeze on stop while the count keeps ramping, then setup clears
    apply(500, 1'b0, 1'b0);
    sb_expect(500);
    apply(500, 1'b0, 1'b1);
    fork
      for (int t = 501; t <= 800; t++) begin @(negedge clk); cur_sec = 16'(t); end
      begin sb_expect(500); sb_expect(500); end
    join
    apply(800, 1'b1, 1'b1);
    sb_expect(0);
    check_display(0);

    // 6: reset during the eighth shift of a pass aborts it
    apply(3210, 1'b0, 1'b0);
    sb_expect(3210);
    begin
      int k;
      for (k = 0; k < 40; k++) begin
        @(negedge clk);
        if (bcd_valid) break;
      end
      chk("valid_seen_before_abort", (k < 40), 1);
    end
    cur_sec = 16'd4321;
    tick(9);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    tick(2);
    release_and_expect(4321);
    tick(45);
    check_display(4321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
